// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out serializer with a one-entry holding buffer and an
// optional idle gap after each frame; feeds the serial sequence detector.
module piso_bit_serializer #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_BIT   = 0,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [7:0]    GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic          HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic          IDLE_LVL = 1'(IDLE_BIT);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [7:0]       gap_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] buf_data;
  logic             buf_full;

  logic             accept;
  logic             end_frame;
  logic             end_gap;
  logic             slot_free;
  logic             load_sr;
  logic             buf_fill;
  logic             buf_drain;
  logic [WIDTH-1:0] sr_word;
  logic [WIDTH-1:0] sr_ord;

  // Words are normalised so the next bit to transmit is always the MSB.
  function automatic logic [WIDTH-1:0] order_word(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST != 0) begin
      r = w;
    end else begin
      for (int i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
    end
    return r;
  endfunction

  assign load_ready = !buf_full;
  assign accept     = load_valid && !buf_full;
  assign end_frame  = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign end_gap    = (state == GAP) && (gap_cnt == GAP_LAST);
  // A slot is free when the shift register can take a word on this edge.
  assign slot_free  = (state == IDLE) || (end_frame && !HAS_GAP) || end_gap;
  assign sr_ord     = order_word(sr_word);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_sr   = 1'b0;
    buf_fill  = 1'b0;
    buf_drain = 1'b0;
    sr_word   = load_data;
    if (slot_free) begin
      if (buf_full) begin
        load_sr   = 1'b1;
        buf_drain = 1'b1;
        sr_word   = buf_data;
      end else if (accept) begin
        load_sr = 1'b1;
      end
    end else if (accept) begin
      buf_fill = 1'b1;
    end
    case (state)
      IDLE: begin
        if (load_sr) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (end_frame) begin
          if (HAS_GAP)      state_nxt = GAP;
          else if (load_sr) state_nxt = SHIFT;
          else              state_nxt = IDLE;
        end
      end
      GAP: begin
        if (end_gap) state_nxt = load_sr ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and registered outputs: reset to the idle line condition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      buf_full   <= 1'b0;
      ser_out    <= IDLE_LVL;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (load_sr || end_frame) bit_cnt <= '0;
      else if (state == SHIFT)  bit_cnt <= bit_cnt + 1'b1;

      if ((state == GAP) && !end_gap) gap_cnt <= gap_cnt + 8'd1;
      else                            gap_cnt <= 8'd0;

      if (buf_fill)       buf_full <= 1'b1;
      else if (buf_drain) buf_full <= 1'b0;

      ser_valid  <= (state_nxt == SHIFT);
      frame_done <= !load_sr && (state == SHIFT) && !end_frame &&
                    (bit_cnt == LAST_BIT - 1'b1);

      if (load_sr)                 ser_out <= sr_ord[WIDTH-1];
      else if (state_nxt == SHIFT) ser_out <= shreg[WIDTH-1];
      else                         ser_out <= IDLE_LVL;
    end
  end

  // Data registers carry no reset; they are only read once qualified.
  always_ff @(posedge clk) begin
    if (load_sr)             shreg <= sr_ord << 1;
    else if (state == SHIFT) shreg <= shreg << 1;
    if (buf_fill) buf_data <= load_data;
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: three configurations (MSB-first, LSB-first,
// two-cycle gap with idle-high) checked against per-instance expected-bit queues.
module tb_piso_bit_serializer;

  typedef struct packed {
    logic v;
    logic b;
    logic fd;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ld_data0 = 8'h00, ld_data1 = 8'h00, ld_data2 = 8'h00;
  logic [2:0] ld_valid = 3'b000;
  logic [2:0] rdy, so, sv, fd;

  localparam logic [2:0] IDLE_L = 3'b100;

  ent_t q0[$];
  ent_t q1[$];
  ent_t q2[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(0), .GAP_CYCLES(0)) u_msb (
    .clk(clk), .rst(rst), .load_data(ld_data0), .load_valid(ld_valid[0]),
    .load_ready(rdy[0]), .ser_out(so[0]), .ser_valid(sv[0]), .frame_done(fd[0]));

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(0), .GAP_CYCLES(0)) u_lsb (
    .clk(clk), .rst(rst), .load_data(ld_data1), .load_valid(ld_valid[1]),
    .load_ready(rdy[1]), .ser_out(so[1]), .ser_valid(sv[1]), .frame_done(fd[1]));

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1), .GAP_CYCLES(2)) u_gap (
    .clk(clk), .rst(rst), .load_data(ld_data2), .load_valid(ld_valid[2]),
    .load_ready(rdy[2]), .ser_out(so[2]), .ser_valid(sv[2]), .frame_done(fd[2]));

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%b expected=%b t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected serial stream of one accepted word, plus gap entries where used.
  task automatic push_word(input int k, input logic [7:0] w);
    ent_t e;
    for (int i = 0; i < 8; i++) begin
      e.v  = 1'b1;
      e.b  = (k == 1) ? w[i] : w[7-i];
      e.fd = (i == 7);
      case (k)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    if (k == 2) begin
      e = '{v: 1'b0, b: 1'b1, fd: 1'b0};
      q2.push_back(e);
      q2.push_back(e);
    end
  endtask

  task automatic step();
    ent_t e;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = '{v: 1'b0, b: IDLE_L[k], fd: 1'b0};
      case (k)
        0: if (q0.size() > 0) e = q0.pop_front();
        1: if (q1.size() > 0) e = q1.pop_front();
        default: if (q2.size() > 0) e = q2.pop_front();
      endcase
      chk("ser_valid", k, sv[k], e.v);
      chk("ser_out", k, so[k], e.b);
      chk("frame_done", k, fd[k], e.fd);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer a word and leave load_valid high; returns cycles spent held off.
  task automatic send(input int k, input logic [7:0] w, output int waited);
    logic done;
    done   = 1'b0;
    waited = 0;
    case (k)
      0: ld_data0 = w;
      1: ld_data1 = w;
      default: ld_data2 = w;
    endcase
    ld_valid[k] = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      if (rdy[k] === 1'b1) begin
        push_word(k, w);
        done = 1'b1;
      end else begin
        waited++;
      end
      step();
    end
    if (!done) begin
      errors++;
      $error("FAIL send_timeout[%0d] observed=no_accept expected=accept", k);
    end
  endtask

  initial begin
    int w;
    int n;

    // Reset state
    step();
    for (int k = 0; k < 3; k++) chk("reset_ready", k, rdy[k], 1'b1);
    steps(2);
    rst = 1'b1;
    steps(2);

    // Test 1: single word, MSB first
    send(0, 8'hB4, w);
    ld_valid[0] = 1'b0;
    steps(10);

    // Test 2: back-to-back with valid held
    send(0, 8'hF0, w);
    send(0, 8'h0F, w);
    chk_int("b2b_second_wait", w, 0);
    ld_valid[0] = 1'b0;
    chk("b2b_ready_low", 0, rdy[0], 1'b0);
    n = 0;
    while (rdy[0] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk_int("b2b_ready_low_cycles", n, 7);
    steps(12);

    // Test 3: three words, third held off by the full buffer
    send(0, 8'h96, w);
    send(0, 8'h5A, w);
    send(0, 8'hC7, w);
    chk_int("third_word_wait", w, 7);
    ld_valid[0] = 1'b0;
    steps(20);

    // Test 4: LSB first
    send(1, 8'h01, w);
    ld_valid[1] = 1'b0;
    steps(10);

    // Test 5: two-cycle gap, idle-high line
    send(2, 8'hAA, w);
    send(2, 8'h55, w);
    ld_valid[2] = 1'b0;
    steps(24);

    // Test 6: asynchronous reset mid-frame with a buffered word
    send(0, 8'hC3, w);
    send(0, 8'h3C, w);
    ld_valid[0] = 1'b0;
    steps(3);
    chk("pre_reset_ready", 0, rdy[0], 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_ser_valid", 0, sv[0], 1'b0);
    chk("async_ser_out", 0, so[0], 1'b0);
    chk("async_frame_done", 0, fd[0], 1'b0);
    chk("async_ready", 0, rdy[0], 1'b1);
    q0.delete();
    ld_data0    = 8'hFF;
    ld_valid[0] = 1'b1;
    steps(3);
    chk("reset_valid_ignored", 0, rdy[0], 1'b1);
    ld_valid[0] = 1'b0;
    rst = 1'b1;
    steps(12);
    send(0, 8'hE5, w);
    ld_valid[0] = 1'b0;
    steps(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
